// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer and round-robin arbiter in front of a single-port,
// byte-wide synchronous data RAM shared by the CPU load/store stage and the loader.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cpu_* / ldr_*            requester ports: req, we, byte, addr, wdata in;
//                            rdata, ack (one-cycle pulse) out
//   mem_en, mem_we           RAM cycle enable / write enable (we only with en)
//   mem_addr, mem_wdata      RAM byte address / write byte
//   mem_rdata                RAM read byte, valid the cycle after a read cycle
//   busy                     high whenever the sequencer is not idle
//
// A word access (16-bit, little-endian) runs LO then HI byte cycles; a byte
// access runs LO only. Read data is assembled in DONE from the byte arriving
// in that cycle and the low byte captured during HI.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  // Loader requester
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_byte,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e              state_q, state_d;
  logic                last_ldr_q, last_ldr_d;  // 1: loader held the most recent grant
  logic                gnt_ldr_q, gnt_ldr_d;    // owner of the current transaction
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          lo_q, lo_d;
  logic [DATA_W-1:0]   cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]   ldr_hold_q, ldr_hold_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ldr_ack_q, ldr_ack_d;

  logic                pick_ldr;
  logic                sel_we;
  logic                sel_byte;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_done;

  // On a tie the requester that did not win last time is granted.
  assign pick_ldr  = ldr_req && (!cpu_req || !last_ldr_q);
  assign sel_we    = pick_ldr ? ldr_we    : cpu_we;
  assign sel_byte  = pick_ldr ? ldr_byte  : cpu_byte;
  assign sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
  assign sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;

  // Only meaningful in DONE of a read: mem_rdata carries the last byte read.
  assign rd_word = byte_q ? {8'h00, mem_rdata} : {mem_rdata, lo_q};
  assign rd_done = (state_q == StDone) && !we_q;

  always_comb begin
    state_d     = state_q;
    last_ldr_d  = last_ldr_q;
    gnt_ldr_d   = gnt_ldr_q;
    we_d        = we_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    cpu_hold_d  = cpu_hold_q;
    ldr_hold_d  = ldr_hold_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req || ldr_req) begin
          gnt_ldr_d   = pick_ldr;
          last_ldr_d  = pick_ldr;
          we_d        = sel_we;
          byte_d      = sel_byte;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          // RAM outputs are registered, so the LO cycle is set up here.
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata[7:0];
          state_d     = StLo;
        end
      end
      StLo: begin
        if (byte_q) begin
          cpu_ack_d = !gnt_ldr_q;
          ldr_ack_d = gnt_ldr_q;
          state_d   = StDone;
        end else begin
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_W'(1);
          mem_wdata_d = wdata_q[15:8];
          state_d     = StHi;
        end
      end
      StHi: begin
        // The low byte read in LO arrives during HI.
        if (!we_q) lo_d = mem_rdata;
        cpu_ack_d = !gnt_ldr_q;
        ldr_ack_d = gnt_ldr_q;
        state_d   = StDone;
      end
      StDone: begin
        if (!we_q) begin
          if (gnt_ldr_q) ldr_hold_d = rd_word;
          else           cpu_hold_d = rd_word;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      last_ldr_q  <= 1'b1;
      gnt_ldr_q   <= 1'b0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      cpu_hold_q  <= '0;
      ldr_hold_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ldr_q  <= last_ldr_d;
      gnt_ldr_q   <= gnt_ldr_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      cpu_hold_q  <= cpu_hold_d;
      ldr_hold_q  <= ldr_hold_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign busy      = (state_q != StIdle);

  assign cpu_rdata = (rd_done && !gnt_ldr_q) ? rd_word : cpu_hold_q;
  assign ldr_rdata = (rd_done && gnt_ldr_q)  ? rd_word : ldr_hold_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencer and arbiter in front of a single-port, byte-wide, synchronous data RAM.
- Shares the RAM between two requesters: the CPU load/store stage and the program/data loader (test preload, debug).
- Word accesses (16-bit, little-endian: low byte at addr, high byte at addr+1) become two byte cycles.
- Byte accesses (lbu/sb) take one RAM cycle; lbu read data is zero-extended.

Parameters:
ADDR_W, 16, byte address width; addr+1 wraps modulo 2^ADDR_W
DATA_W, 16, requester data width; fixed at 2 bytes, no other value supported

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_we  input  1  1 = store, 0 = load
cpu_byte  input  1  1 = byte access (lbu/sb), 0 = word
cpu_addr  input  ADDR_W  CPU byte address
cpu_wdata  input  DATA_W  CPU store data (byte store uses [7:0])
cpu_rdata  output  DATA_W  CPU load data
cpu_ack  output  1  one-cycle completion pulse to CPU
ldr_req, ldr_we, ldr_byte, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same directions, widths and meanings as the cpu_* set, for the loader
mem_en  output  1  RAM cycle enable
mem_we  output  1  RAM write enable, valid only with mem_en
mem_addr  output  ADDR_W  RAM byte address
mem_wdata  output  8  RAM write byte
mem_rdata  input  8  RAM read byte, valid in the cycle after the mem_en read cycle
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ack=ldr_ack=0, cpu_rdata=ldr_rdata=0, busy=0, last_grant=LDR (so the CPU wins the first tie).
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If any request is high, select a winner.
  - Latch the winner's we, byte, addr and wdata, then go to LO.
  - If both requests are high, grant the requester not in last_grant (round-robin); update last_grant on every grant.
  - If neither request is high, stay in IDLE.
- LO:
  - mem_en=1, mem_addr=addr, mem_we=we, mem_wdata=wdata[7:0].
  - Next state is DONE for a byte access, HI for a word access.
- HI:
  - mem_en=1, mem_addr=addr+1 (wraps: 16'hFFFF -> 16'h0000), mem_we=we, mem_wdata=wdata[15:8].
  - On a read, capture mem_rdata (the low byte) into lo_reg at the end of HI.
  - Next state is DONE.
- DONE:
  - mem_en=0. Assert the granted port's ack for exactly this cycle.
  - For a read, the granted port's rdata equals {mem_rdata, lo_reg} for a word, or {8'h00, mem_rdata} for a byte, and is registered into that port's hold register at the end of DONE.
  - Next state is IDLE.
- rdata hold: outside DONE, each port's rdata shows its hold register. Writes never change the hold registers. The non-granted port's rdata never changes.
- mem_en=0 in IDLE and DONE, so mem_we is never high without mem_en.
- Latency, counted from the first IDLE cycle with req high:
  - byte access: ack in cycle +2;
  - word access: ack in cycle +3.
  - There is a minimum of one IDLE cycle between transactions. Requests are not sampled in DONE.
- Requester rules: req, we, byte, addr and wdata stay stable from assertion until ack. The controller uses only the values latched at grant; later changes are ignored.
- Boundary conditions:
  - A request dropped mid-transaction still completes, and the ack still pulses.
  - A request still high in the cycle after ack is treated as a new request.
  - A losing requester keeps req high and is served next; it waits at most one transaction.
- Reset mid-operation: takes effect immediately. The FSM goes to IDLE, mem_en drops, the in-flight transaction is abandoned with no ack, and a word write may leave only its low byte written.

Test Plan:
- Word read, CPU only: RAM[0x0004]=0x12, RAM[0x0005]=0x43; cpu_req, addr=0x0004, we=0, byte=0 -> mem_en in cycles +1 and +2 with addr 0x0004 then 0x0005; cpu_ack in cycle +3 with cpu_rdata=0x4312; ldr_ack stays 0.
- Byte read and byte write: lbu at 0x0006 (RAM=0xDE) -> cpu_rdata=0x00DE, ack in cycle +2. sb 0xAB55 at 0x0008 -> only RAM[0x0008]=0x55 is written; RAM[0x0009] unchanged; exactly one mem_we cycle.
- Word write with wrap: loader word write 0xBEEF at 0xFFFF -> RAM[0xFFFF]=0xEF, RAM[0x0000]=0xBE; second mem_addr=0x0000.
- Simultaneous requests: both req high from reset -> CPU served first, loader next. Repeat with both held high -> grants alternate CPU, LDR, CPU, LDR; each ack is one cycle; IDLE appears between transactions.
- Reset mid-operation: assert reset_n=0 during HI of a word write -> mem_en=0, busy=0 and no ack immediately (before the next edge). After release, a new request completes normally.
- Stability: change cpu_addr and cpu_wdata after grant, before ack -> RAM accesses use the latched values; ldr_rdata unchanged throughout the CPU transactions.
